// File: rtl/tx_ring_reader_if.sv
// Bus bundle for tx_ring_reader: ring RAM read port, pointers, byte stream and status.
// master = the reader, slave = ring/CPU/modulator side.
interface tx_ring_reader_if #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) ();
  logic                    en_i;
  logic [ADDR_W-1:0]       wp_i;
  logic [ADDR_W-1:0]       rp_o;
  logic [ADDR_W-1:0]       raddr_o;
  logic                    rce_o;
  logic [8*WORD_BYTES-1:0] rdata_i;
  logic [7:0]              byte_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    begin_o;
  logic                    end_o;
  logic                    aborted_o;
  logic                    abort_i;
  logic                    err_o;
  logic                    clk_req_o;
  logic                    irq_o;

  modport master (
    input  en_i, wp_i, rdata_i, ready_i, abort_i,
    output rp_o, raddr_o, rce_o, byte_o, valid_o, begin_o, end_o,
           aborted_o, err_o, clk_req_o, irq_o
  );

  modport slave (
    output en_i, wp_i, rdata_i, ready_i, abort_i,
    input  rp_o, raddr_o, rce_o, byte_o, valid_o, begin_o, end_o,
           aborted_o, err_o, clk_req_o, irq_o
  );
endinterface

// File: rtl/tx_ring_reader.sv
// TX ring reader: length-prefixed messages from ring RAM streamed out byte-by-byte.
// Define TX_RING_PREFETCH_EN to add a second word buffer that hides payload read latency.
module tx_ring_reader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int LEN_W      = 10
) (
  input  logic            clk,
  input  logic            rst,
  tx_ring_reader_if.master bus
);
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam int DW    = 8 * WORD_BYTES;
  localparam int CW    = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 4;

  typedef enum logic [2:0] {
    IDLE, HDR_REQ, HDR_LAT, PL_REQ, PL_LAT, STREAM, FINISH, ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rp, raddr;
  logic [LEN_W-1:0]  len, idx;
  logic [CW-1:0]     nwords;
  logic [DW-1:0]     wbuf;
  logic [7:0]        byte_q;
  logic              rce, valid, begin_p, end_p, aborted, err, irq;

  logic [LEN_W-1:0]  hdr_len, idx_n;
  logic [CW-1:0]     hdr_words, avail;
  logic              last_lane, last_byte, abort_now;

  assign hdr_len   = bus.rdata_i[LEN_W-1:0];
  assign hdr_words = (CW'(hdr_len) + CW'(WORD_BYTES - 1)) >> WB_SH;
  // avail is taken modulo ring depth before widening so wrap-around is transparent
  assign avail     = CW'(ADDR_W'(bus.wp_i - rp));
  assign idx_n     = idx + LEN_W'(1);
  assign last_lane = (idx & LEN_W'(WORD_BYTES - 1)) == LEN_W'(WORD_BYTES - 1);
  assign last_byte = (idx == len - LEN_W'(1));
  // a byte whose handshake completes with abort still counts; the final byte wins over abort
  assign abort_now = bus.abort_i &&
                     (state == PL_REQ || state == PL_LAT ||
                      (state == STREAM && !(bus.ready_i && last_byte)));

  function automatic logic [7:0] lane_byte(input logic [DW-1:0] w, input logic [LEN_W-1:0] i);
    logic [DW-1:0] s;
    s = w >> (8 * int'(i & LEN_W'(WORD_BYTES - 1)));
    return s[7:0];
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  i);
    return base + ADDR_W'(1) + ADDR_W'(i >> WB_SH);
  endfunction

`ifdef TX_RING_PREFETCH_EN
  logic [DW-1:0] nbuf, pf_word;
  logic          nbuf_vld, pf_issue, pf_data;

  // the prefetched word may be landing on rdata_i in the very cycle the lane boundary is crossed
  assign pf_word = nbuf_vld ? nbuf : bus.rdata_i;

  function automatic logic more_words(input logic [LEN_W-1:0] i, input logic [CW-1:0] n);
    return (WORD_BYTES > 1) && ((CW'(i >> WB_SH) + CW'(1)) < n);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rp      <= '0;
      raddr   <= '0;
      len     <= '0;
      idx     <= '0;
      nwords  <= '0;
      wbuf    <= '0;
      byte_q  <= '0;
      rce     <= 1'b0;
      valid   <= 1'b0;
      begin_p <= 1'b0;
      end_p   <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      irq     <= 1'b0;
`ifdef TX_RING_PREFETCH_EN
      nbuf     <= '0;
      nbuf_vld <= 1'b0;
      pf_issue <= 1'b0;
      pf_data  <= 1'b0;
`endif
    end else begin
      rce     <= 1'b0;
      begin_p <= 1'b0;
      end_p   <= 1'b0;
      aborted <= 1'b0;
      irq     <= 1'b0;
`ifdef TX_RING_PREFETCH_EN
      pf_issue <= 1'b0;
      pf_data  <= pf_issue;
      if (pf_data) begin
        nbuf     <= bus.rdata_i;
        nbuf_vld <= 1'b1;
      end
`endif
      if (abort_now) begin
        state   <= FINISH;
        end_p   <= 1'b1;
        aborted <= 1'b1;
        irq     <= 1'b1;
        valid   <= 1'b0;
`ifdef TX_RING_PREFETCH_EN
        nbuf_vld <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (bus.en_i && bus.wp_i != rp) begin
            state   <= HDR_REQ;
            rce     <= 1'b1;
            raddr   <= rp;
            begin_p <= 1'b1;
          end
          HDR_REQ: state <= HDR_LAT;
          HDR_LAT: begin
            len    <= hdr_len;
            idx    <= '0;
            nwords <= hdr_words;
`ifdef TX_RING_PREFETCH_EN
            nbuf_vld <= 1'b0;
`endif
            if (hdr_words + CW'(1) > avail) begin
              state <= ERROR;
              err   <= 1'b1;
              irq   <= 1'b1;
            end else if (hdr_len == '0) begin
              state <= FINISH;
              end_p <= 1'b1;
              irq   <= 1'b1;
            end else begin
              state <= PL_REQ;
              rce   <= 1'b1;
              raddr <= rp + ADDR_W'(1);
            end
          end
          PL_REQ: state <= PL_LAT;
          PL_LAT: begin
            state  <= STREAM;
            wbuf   <= bus.rdata_i;
            byte_q <= lane_byte(bus.rdata_i, idx);
            valid  <= 1'b1;
`ifdef TX_RING_PREFETCH_EN
            if (more_words(idx, nwords)) begin
              rce      <= 1'b1;
              pf_issue <= 1'b1;
              raddr    <= word_addr(rp, idx) + ADDR_W'(1);
            end
`endif
          end
          STREAM: if (bus.ready_i) begin
            if (last_byte) begin
              state <= FINISH;
              valid <= 1'b0;
              end_p <= 1'b1;
              irq   <= 1'b1;
            end else begin
              idx <= idx_n;
              if (!last_lane) begin
                byte_q <= lane_byte(wbuf, idx_n);
              end
`ifdef TX_RING_PREFETCH_EN
              else if (nbuf_vld || pf_data) begin
                wbuf     <= pf_word;
                byte_q   <= lane_byte(pf_word, idx_n);
                nbuf_vld <= 1'b0;
                if (more_words(idx_n, nwords)) begin
                  rce      <= 1'b1;
                  pf_issue <= 1'b1;
                  raddr    <= word_addr(rp, idx_n) + ADDR_W'(1);
                end
              end
`endif
              else begin
                state <= PL_REQ;
                valid <= 1'b0;
                rce   <= 1'b1;
                raddr <= word_addr(rp, idx_n);
              end
            end
          end
          FINISH: begin
            rp    <= rp + ADDR_W'(1) + ADDR_W'(nwords);
            state <= IDLE;
          end
          ERROR: begin
            rp    <= bus.wp_i;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rp_o      = rp;
  assign bus.raddr_o   = raddr;
  assign bus.rce_o     = rce;
  assign bus.byte_o    = byte_q;
  assign bus.valid_o   = valid;
  assign bus.begin_o   = begin_p;
  assign bus.end_o     = end_p;
  assign bus.aborted_o = aborted;
  assign bus.err_o     = err;
  assign bus.irq_o     = irq;
  assign bus.clk_req_o = (state != IDLE);
endmodule
